mem_seq: RTL and testbench

Memory sequencer and arbiter sharing the single byte-wide memory between three requesters: debug/loader port, core load/store, and core instruction fetch. Arbitrates the requests, splits each byte, half or word access into byte beats on the memory port, and assembles read data little-endian. Sits between the core control unit and the memory array; it is the only block that drives memory address and strobes.

---
 rtl/mem_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_mem_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq.sv
// mem_seq: memory sequencer and arbiter for the single byte-wide memory.
//
// Three requesters share the memory: debug/loader (0), core data (1) and
// core fetch (2). One request is granted per IDLE cycle, split into byte
// beats on the memory port, and answered with a one-cycle rq_done pulse.
// Read data is assembled little-endian and zero-extended.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset (release synchronised here)
//   rq_valid   per-requester request valid, held until its rq_done
//   rq_we      per-requester write enable (1 = store)
//   rq_addr    per-requester byte address, requester i at [i*ADDR_W +: ADDR_W]
//   rq_size    per-requester size at [2i +: 2]: 00 byte, 01 half, 10 word
//   rq_wdata   per-requester store data at [32i +: 32], little-endian
//   rq_done    one-cycle completion pulse to the granted requester
//   rq_err     misaligned or reserved size, valid with rq_done
//   rd_data    zero-extended read result, valid with rq_done
//   mem_addr   byte address to memory
//   mem_wdata  write byte
//   mem_we     write strobe
//   mem_re     read strobe
//   mem_rdata  read byte, combinational from mem_addr
module mem_seq #(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            rq_valid,
  input  logic [2:0]            rq_we,
  input  logic [3*ADDR_W-1:0]   rq_addr,
  input  logic [5:0]            rq_size,
  input  logic [95:0]           rq_wdata,
  output logic [2:0]            rq_done,
  output logic                  rq_err,
  output logic [31:0]           rd_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic [1:0]          rst_sync_q;
  logic                rst_n_s;
  logic [1:0]          id_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [1:0]          idx_q;
  logic [1:0]          last_q;
  logic [1:0]          starve_q;
  logic [2:0]          rq_done_q;
  logic                rq_err_q;
  logic [31:0]         rd_data_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                mem_we_q;
  logic                mem_re_q;

  logic                gnt_any_s;
  logic [1:0]          gnt_id_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [1:0]          sel_size_s;
  logic [31:0]         sel_wdata_s;
  logic                sel_err_s;
  logic [1:0]          sel_last_s;
  logic [1:0]          starve_d;
  logic [1:0]          idx_nx_s;
  logic [31:0]         rdata_d;
  logic [7:0]          wbyte_nx_s;

  // Reset release synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Arbitration: debug first; fetch wins over data when data is idle or
  // after two consecutive data grants that made fetch wait.
  always_comb begin
    gnt_any_s = 1'b1;
    gnt_id_s  = 2'd0;
    if (rq_valid[0]) begin
      gnt_id_s = 2'd0;
    end else if (rq_valid[2] && ((starve_q == 2'd2) || !rq_valid[1])) begin
      gnt_id_s = 2'd2;
    end else if (rq_valid[1]) begin
      gnt_id_s = 2'd1;
    end else begin
      gnt_any_s = 1'b0;
    end
  end

  // Starvation count: only a data grant while fetch waits advances it.
  always_comb begin
    if ((gnt_id_s == 2'd1) && rq_valid[2]) begin
      starve_d = starve_q + 2'd1;
    end else begin
      starve_d = 2'd0;
    end
  end

  // Winner's request fields.
  always_comb begin
    sel_we_s    = rq_we[gnt_id_s];
    sel_addr_s  = rq_addr[gnt_id_s*ADDR_W +: ADDR_W];
    sel_size_s  = rq_size[gnt_id_s*2 +: 2];
    sel_wdata_s = rq_wdata[gnt_id_s*32 +: 32];
  end

  // Alignment check and beat count for the winner.
  always_comb begin
    case (sel_size_s)
      2'b00: begin
        sel_err_s  = 1'b0;
        sel_last_s = 2'd0;
      end
      2'b01: begin
        sel_err_s  = sel_addr_s[0];
        sel_last_s = 2'd1;
      end
      2'b10: begin
        sel_err_s  = |sel_addr_s[1:0];
        sel_last_s = 2'd3;
      end
      default: begin
        sel_err_s  = 1'b1;
        sel_last_s = 2'd0;
      end
    endcase
  end

  // Beat datapath: next index, next store byte, accumulator with this beat.
  always_comb begin
    idx_nx_s   = idx_q + 2'd1;
    wbyte_nx_s = wdata_q[{idx_nx_s, 3'b000} +: 8];
    rdata_d    = rdata_q;
    rdata_d[{idx_q, 3'b000} +: 8] = mem_rdata;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q     <= S_IDLE;
      id_q        <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      starve_q    <= 2'd0;
      rq_done_q   <= 3'b000;
      rq_err_q    <= 1'b0;
      rd_data_q   <= 32'h0000_0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_any_s) begin
            id_q     <= gnt_id_s;
            we_q     <= sel_we_s;
            addr_q   <= sel_addr_s;
            wdata_q  <= sel_wdata_s;
            rdata_q  <= 32'h0000_0000;
            idx_q    <= 2'd0;
            last_q   <= sel_last_s;
            starve_q <= starve_d;
            if (sel_err_s) begin
              // Rejected without touching memory.
              state_q   <= S_RESP;
              rq_done_q <= 3'b001 << gnt_id_s;
              rq_err_q  <= 1'b1;
            end else begin
              state_q     <= S_XFER;
              mem_addr_q  <= sel_addr_s;
              mem_wdata_q <= sel_we_s ? sel_wdata_s[7:0] : 8'h00;
              mem_we_q    <= sel_we_s;
              mem_re_q    <= !sel_we_s;
            end
          end
        end
        S_XFER: begin
          if (!we_q) begin
            rdata_q <= rdata_d;
          end
          if (idx_q == last_q) begin
            state_q     <= S_RESP;
            rq_done_q   <= 3'b001 << id_q;
            rd_data_q   <= we_q ? 32'h0000_0000 : rdata_d;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
          end else begin
            idx_q       <= idx_nx_s;
            // Plain ADDR_W addition: wraps, no carry out.
            mem_addr_q  <= addr_q + {{(ADDR_W-2){1'b0}}, idx_nx_s};
            mem_wdata_q <= we_q ? wbyte_nx_s : 8'h00;
          end
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          rq_done_q <= 3'b000;
          rq_err_q  <= 1'b0;
          rd_data_q <= 32'h0000_0000;
        end
        default: begin
          state_q     <= S_IDLE;
          rq_done_q   <= 3'b000;
          rq_err_q    <= 1'b0;
          rd_data_q   <= 32'h0000_0000;
          mem_addr_q  <= '0;
          mem_wdata_q <= 8'h00;
          mem_we_q    <= 1'b0;
          mem_re_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rq_done   = rq_done_q;
  assign rq_err    = rq_err_q;
  assign rd_data   = rd_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: scoreboard bench for mem_seq with a byte-memory model.
module tb_mem_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rq_valid = 3'b000;
  logic [2:0]  rq_we = 3'b000;
  logic [95:0] rq_addr = 96'h0;
  logic [5:0]  rq_size = 6'h0;
  logic [95:0] rq_wdata = 96'h0;
  logic [2:0]  rq_done;
  logic        rq_err;
  logic [31:0] rd_data;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [logic [31:0]];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          re_cnt = 0;
  int          overlap = 0;

  mem_seq #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rq_valid(rq_valid), .rq_we(rq_we),
    .rq_addr(rq_addr), .rq_size(rq_size), .rq_wdata(rq_wdata),
    .rq_done(rq_done), .rq_err(rq_err), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Memory model, response monitor and strobe watch, all on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (rq_done != 3'b000)) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {29'd0, rq_done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_id", {29'd0, rq_done}, 32'd1 << e.id);
        chk("err", {31'd0, rq_err}, {31'd0, e.err});
        chk("rd_data", rd_data, e.data);
        if (e.due >= 0) chk("latency", cyc, e.due);
      end
    end
    if (mem_we && mem_re) overlap++;
    if (mem_re) re_cnt++;
    if (mem_we) mem[mem_addr] = mem_wdata;
    mem_rdata = mem_rd(mem_addr);
  end

  // Single request, driven in an IDLE cycle; waits for its completion.
  task automatic do_req(input int id, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_data,
                        input int beats);
    bit got = 1'b0;
    @(negedge clk);
    rq_we[id]             = we;
    rq_addr[id*32 +: 32]  = addr;
    rq_size[id*2 +: 2]    = size;
    rq_wdata[id*32 +: 32] = wdata;
    rq_valid[id]          = 1'b1;
    sb.push_back('{id, exp_err, exp_data, cyc + beats + 1});
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rq_done[id]) got = 1'b1;
    end
    if (!got) chk("req_timeout", 32'd0, 32'd1);
    rq_valid[id] = 1'b0;
  endtask

  task automatic set_rd(input int id, input logic [31:0] addr);
    rq_we[id]            = 1'b0;
    rq_addr[id*32 +: 32] = addr;
    rq_size[id*2 +: 2]   = 2'b00;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_done"}, {29'd0, rq_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, rq_err}, 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
  endtask

  initial begin
    int got;
    int re0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Word write then word read back through the data port.
    do_req(0, 1'b1, 32'h40, 2'b10, 32'h1122_3344, 1'b0, 32'h0, 4);
    chk("mem40", {24'd0, mem_rd(32'h40)}, 32'h44);
    chk("mem41", {24'd0, mem_rd(32'h41)}, 32'h33);
    chk("mem42", {24'd0, mem_rd(32'h42)}, 32'h22);
    chk("mem43", {24'd0, mem_rd(32'h43)}, 32'h11);
    do_req(1, 1'b0, 32'h40, 2'b10, 32'h0, 1'b0, 32'h1122_3344, 4);

    // Misaligned half: error, no read strobe.
    re0 = re_cnt;
    do_req(2, 1'b0, 32'h41, 2'b01, 32'h0, 1'b1, 32'h0, 0);
    chk("err_no_re", re_cnt - re0, 32'd0);
    do_req(2, 1'b0, 32'h43, 2'b00, 32'h0, 1'b0, 32'h11, 1);

    // Half write and read back; reserved size.
    do_req(1, 1'b1, 32'h50, 2'b01, 32'h1234_BEEF, 1'b0, 32'h0, 2);
    chk("mem50", {24'd0, mem_rd(32'h50)}, 32'hEF);
    chk("mem51", {24'd0, mem_rd(32'h51)}, 32'hBE);
    chk("mem52", {24'd0, mem_rd(32'h52)}, 32'h00);
    do_req(1, 1'b0, 32'h50, 2'b01, 32'h0, 1'b0, 32'h0000_BEEF, 2);
    do_req(0, 1'b0, 32'h44, 2'b11, 32'h0, 1'b1, 32'h0, 0);

    // All three requesters at once.
    @(negedge clk);
    set_rd(0, 32'h40); set_rd(1, 32'h41); set_rd(2, 32'h42);
    sb.push_back('{0, 1'b0, 32'h44, -1});
    sb.push_back('{1, 1'b0, 32'h33, -1});
    sb.push_back('{2, 1'b0, 32'h22, -1});
    rq_valid = 3'b111;
    got = 0;
    for (int k = 0; k < 40 && got < 3; k++) begin
      @(negedge clk);
      if (rq_done != 3'b000) begin
        rq_valid = rq_valid & ~rq_done;
        got++;
      end
    end
    chk("prio_count", got, 32'd3);
    rq_valid = 3'b000;

    // Data and fetch held continuously: fetch gets every third grant.
    @(negedge clk);
    set_rd(1, 32'h40); set_rd(2, 32'h43);
    for (int k = 0; k < 6; k++) begin
      if ((k % 3) == 2) sb.push_back('{2, 1'b0, 32'h11, -1});
      else sb.push_back('{1, 1'b0, 32'h44, -1});
    end
    rq_valid = 3'b110;
    got = 0;
    for (int k = 0; k < 60 && got < 6; k++) begin
      @(negedge clk);
      if (rq_done != 3'b000) got++;
    end
    chk("starve_count", got, 32'd6);
    rq_valid = 3'b000;

    // Top-of-memory word write; must not wrap onto address 0.
    mem[32'h0] = 8'h5A;
    do_req(0, 1'b1, 32'hFFFF_FFFC, 2'b10, 32'hAABB_CCDD, 1'b0, 32'h0, 4);
    chk("memFC", {24'd0, mem_rd(32'hFFFF_FFFC)}, 32'hDD);
    chk("memFD", {24'd0, mem_rd(32'hFFFF_FFFD)}, 32'hCC);
    chk("memFE", {24'd0, mem_rd(32'hFFFF_FFFE)}, 32'hBB);
    chk("memFF", {24'd0, mem_rd(32'hFFFF_FFFF)}, 32'hAA);
    chk("mem00", {24'd0, mem_rd(32'h0)}, 32'h5A);
    do_req(0, 1'b1, 32'hFFFF_FFFE, 2'b10, 32'h0102_0304, 1'b1, 32'h0, 0);
    chk("memFE_kept", {24'd0, mem_rd(32'hFFFF_FFFE)}, 32'hBB);

    // Reset in the second beat of a word write.
    for (int a = 0; a < 4; a++) mem[32'h80 + a] = 8'hEE;
    @(negedge clk);
    rq_we[0] = 1'b1; rq_addr[31:0] = 32'h80; rq_size[1:0] = 2'b10;
    rq_wdata[31:0] = 32'h0102_0304;
    rq_valid[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_outs_zero("midrst");
    @(negedge clk);
    rq_valid = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("mem80", {24'd0, mem_rd(32'h80)}, 32'h04);
    chk("mem81", {24'd0, mem_rd(32'h81)}, 32'hEE);
    chk("mem83", {24'd0, mem_rd(32'h83)}, 32'hEE);
    do_req(2, 1'b0, 32'h80, 2'b00, 32'h0, 1'b0, 32'h04, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("strobe_overlap", overlap, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
